// File: rtl/alu_ops_pkg.sv
// alu_ops_pkg
//   Operation codes and FSM state encoding for the multicycle ALU. The ALU
//   control unit imports the same package, so each code is defined only here.
package alu_ops_pkg;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_NOR     = 4'b0010;
  localparam logic [3:0] ALU_ADD     = 4'b0011;
  localparam logic [3:0] ALU_SLL     = 4'b0100;
  localparam logic [3:0] ALU_SRL     = 4'b0101;
  localparam logic [3:0] ALU_LUI     = 4'b1000;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // True for the two codes that use the iterative shifter.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/shift_iter_unit.sv
// shift_iter_unit
//   Iterative logical shifter: one bit per clock, zero fill.
//   Ports:
//     clk, reset   - clock, synchronous active-low reset
//     load         - capture value/amount/dir (takes priority over stepping)
//     dir          - 0 = left (SLL), 1 = right (SRL)
//     value        - operand to shift
//     amount       - number of one-bit steps
//     shifted      - register contents after the step the next edge performs
//     last_step    - the next edge performs the final step (counter 1 -> 0)
module shift_iter_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   dir,
  input  logic [DATA_WIDTH-1:0]  value,
  input  logic [SHAMT_WIDTH-1:0] amount,
  output logic [DATA_WIDTH-1:0]  shifted,
  output logic                   last_step
);

  logic [DATA_WIDTH-1:0]  shift_reg;
  logic [SHAMT_WIDTH-1:0] count_reg;
  logic                   dir_reg;
  logic [DATA_WIDTH-1:0]  shift_left;
  logic [DATA_WIDTH-1:0]  shift_right;

  // One-bit shifts in both directions, zero filled at the vacated end.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign shift_left[gi] = 1'b0;
      end else begin : g_lmid
        assign shift_left[gi] = shift_reg[gi-1];
      end
      if (gi == DATA_WIDTH - 1) begin : g_msb
        assign shift_right[gi] = 1'b0;
      end else begin : g_rmid
        assign shift_right[gi] = shift_reg[gi+1];
      end
    end
  endgenerate

  assign shifted   = dir_reg ? shift_right : shift_left;
  assign last_step = (count_reg == SHAMT_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_reg <= '0;
      count_reg <= '0;
      dir_reg   <= 1'b0;
    end else if (load) begin
      shift_reg <= value;
      count_reg <= amount;
      dir_reg   <= dir;
    end else if (count_reg != '0) begin
      shift_reg <= shifted;
      count_reg <= count_reg - SHAMT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle
//   Execute-stage ALU. AND/OR/NOR/ADD/LUI and zero-amount shifts finish one
//   cycle after the accepting edge; SLL/SRL with a nonzero amount run on the
//   iterative shifter and hold busy until the final step.
//   Ports:
//     clk, reset     - clock, synchronous active-low reset
//     start          - operation request, sampled only while idle
//     alu_operation  - 4-bit operation code from ALU control
//     a, b           - operands; b is the shifted operand
//     shamt          - shift amount
//     busy           - a multicycle shift is in progress
//     done           - one-cycle pulse, result/zero/illegal valid
//     result, zero   - registered result and result==0 flag
//     illegal        - last completed operation code was unsupported
module alu_multicycle
  import alu_ops_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             alu_operation,
  input  logic [DATA_WIDTH-1:0]  a,
  input  logic [DATA_WIDTH-1:0]  b,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   zero,
  output logic                   illegal
);

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] op_result;
  logic                  op_illegal;
  logic                  op_is_shift;
  logic                  shift_load;
  logic [DATA_WIDTH-1:0] shift_value;
  logic                  shift_last;

  // Single-cycle result. Shift codes pass b through, which is the correct
  // answer for a zero shift amount; nonzero amounts go to the shifter.
  // Illegal codes yield zero so the zero flag is set along with illegal.
  always_comb begin
    op_result  = '0;
    op_illegal = 1'b0;
    case (alu_operation)
      ALU_AND: op_result = a & b;
      ALU_OR:  op_result = a | b;
      ALU_NOR: op_result = ~(a | b);
      ALU_ADD: op_result = a + b;
      ALU_LUI: op_result = b << 16;
      ALU_SLL,
      ALU_SRL: op_result = b;
      default: op_illegal = 1'b1;
    endcase
  end

  assign op_is_shift = is_shift_op(alu_operation);
  assign shift_load  = (state_reg == ST_IDLE) && start && op_is_shift &&
                       (shamt != '0);

  shift_iter_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (shift_load),
    .dir      (alu_operation == ALU_SRL),
    .value    (b),
    .amount   (shamt),
    .shifted  (shift_value),
    .last_step(shift_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (shift_load) begin
              busy      <= 1'b1;
              state_reg <= ST_SHIFT;
            end else begin
              result  <= op_result;
              zero    <= (op_result == '0);
              illegal <= op_illegal;
              done    <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          // shift_value is the register after this edge's step, so on the
          // final step it is the finished result.
          if (shift_last) begin
            result    <= shift_value;
            zero      <= (shift_value == '0);
            illegal   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;
  import alu_ops_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  alu_operation;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  alu_multicycle #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .alu_operation(alu_operation),
    .a            (a),
    .b            (b),
    .shamt        (shamt),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .zero         (zero),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one active edge; inputs are driven and outputs sampled at negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] va,
                       input logic [31:0] vb, input logic [4:0] sa);
    start         = 1'b1;
    alu_operation = op;
    a             = va;
    b             = vb;
    shamt         = sa;
  endtask

  int n;
  int busy_cnt;

  initial begin
    reset = 1'b0;
    drive(ALU_ADD, 32'h1, 32'h1, 5'd0);
    @(negedge clk);
    tick();
    tick();
    check("rst_done",    32'(done),    32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_result",  result,       32'd0);
    check("rst_zero",    32'(zero),    32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);

    // ADD wraps to zero
    reset = 1'b1;
    drive(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 5'd0);
    tick();
    check("add_done",    32'(done),    32'd1);
    check("add_result",  result,       32'd0);
    check("add_zero",    32'(zero),    32'd1);
    check("add_illegal", 32'(illegal), 32'd0);

    // NOR back-to-back in the done cycle
    drive(ALU_NOR, 32'h0, 32'h0, 5'd0);
    tick();
    check("nor_done",   32'(done), 32'd1);
    check("nor_result", result,    32'hFFFF_FFFF);
    check("nor_zero",   32'(zero), 32'd0);
    start = 1'b0;
    tick();
    check("idle_done",   32'(done), 32'd0);
    check("idle_result", result,    32'hFFFF_FFFF);

    // SLL by 31 with an ignored start mid-shift
    drive(ALU_SLL, 32'h0, 32'h0000_0001, 5'd31);
    tick();
    check("sll_busy0", 32'(busy), 32'd1);
    check("sll_done0", 32'(done), 32'd0);
    start = 1'b0;
    busy_cnt = 1;
    n = 0;
    while (!done && n < 100) begin
      if (n == 5) drive(ALU_AND, 32'h0, 32'h0, 5'd0);
      if (n == 6) begin start = 1'b0; b = 32'hDEAD_BEEF; shamt = 5'd3; end
      tick();
      n++;
      if (busy) busy_cnt++;
    end
    check("sll_edges",   32'(n),        32'd31);
    check("sll_busycnt", 32'(busy_cnt), 32'd31);
    check("sll_result",  result,        32'h8000_0000);
    check("sll_busy_end",32'(busy),     32'd0);
    check("sll_zero",    32'(zero),     32'd0);
    tick();
    check("sll_done_pulse", 32'(done), 32'd0);

    // SRL by zero completes in one cycle
    drive(ALU_SRL, 32'h0, 32'h8000_0000, 5'd0);
    tick();
    check("srl0_done",   32'(done), 32'd1);
    check("srl0_busy",   32'(busy), 32'd0);
    check("srl0_result", result,    32'h8000_0000);

    // Illegal codes
    drive(ALU_ILLEGAL, 32'd5, 32'd7, 5'd0);
    tick();
    check("ill15_done",    32'(done),    32'd1);
    check("ill15_illegal", 32'(illegal), 32'd1);
    check("ill15_result",  result,       32'd0);
    check("ill15_zero",    32'(zero),    32'd1);
    drive(4'b0110, 32'd5, 32'd7, 5'd0);
    tick();
    check("ill6_done",    32'(done),    32'd1);
    check("ill6_illegal", 32'(illegal), 32'd1);
    check("ill6_zero",    32'(zero),    32'd1);
    drive(ALU_LUI, 32'h0, 32'h0000_1234, 5'd0);
    tick();
    check("lui_done",    32'(done),    32'd1);
    check("lui_result",  result,       32'h1234_0000);
    check("lui_illegal", 32'(illegal), 32'd0);
    check("lui_zero",    32'(zero),    32'd0);

    // SLL by 10 aborted by reset during the 4th shift cycle
    drive(ALU_SLL, 32'h0, 32'h0000_0001, 5'd10);
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    check("abort_done",   32'(done), 32'd0);
    check("abort_busy",   32'(busy), 32'd0);
    check("abort_result", result,    32'd0);
    reset = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) busy_cnt++;
    end
    check("abort_no_done", 32'(busy_cnt), 32'd0);

    // AND after reset
    drive(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
    tick();
    check("and_done",   32'(done), 32'd1);
    check("and_result", result,    32'hF000_F000);
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
